// File: rtl/eth_fcs_append.sv
// eth_fcs_append: TX framer stage that forwards payload, zero-pads to MIN_LEN, appends CRC-32 FCS and enforces an inter-frame gap.
module eth_fcs_append #(
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12,
  parameter int CW      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_err
);
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, PAD = 3'd2, FCS = 3'd3, IFG = 3'd4;
  localparam logic [31:0] MIN_L = MIN_LEN;
  localparam logic [31:0] IFG_L = IFG_LEN;
  logic [2:0]    state;
  logic [31:0]   crc;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_next;
  logic [31:0]   cnt_ext;
  logic [1:0]    fidx;
  logic [31:0]   ifg_cnt;
  logic [31:0]   fcs;
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
    return r;
  endfunction
  assign s_ready  = gate & (state == IDLE | state == DATA);
  assign cnt_next = (count == '1) ? count : count + CW'(1);
  assign cnt_ext  = {{(32-CW){1'b0}}, cnt_next};
  assign fcs      = ~crc >> {fidx, 3'b000};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_data  <= 8'h00;
      o_last  <= 1'b0;
      o_err   <= 1'b0;
      crc     <= '1;
      count   <= '0;
      fidx    <= 2'd0;
      ifg_cnt <= 32'd0;
    end else if (gate) begin
      o_last <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          o_valid <= s_valid;
          if (s_valid) begin
            o_data <= s_data;
            crc    <= crc_upd(32'hFFFFFFFF, s_data);
            count  <= CW'(1);
            state  <= !s_last ? DATA : (MIN_L > 32'd1 ? PAD : FCS);
          end
        end
        DATA: begin
          o_valid <= s_valid;
          if (s_valid) begin
            o_data <= s_data;
            crc    <= crc_upd(crc, s_data);
            count  <= cnt_next;
            if (s_last) state <= (cnt_ext < MIN_L) ? PAD : FCS;
          end else begin
            // underrun: drop the frame and restart CRC for the next one
            o_err   <= 1'b1;
            crc     <= '1;
            count   <= '0;
            ifg_cnt <= 32'd0;
            state   <= (IFG_L == 32'd0) ? IDLE : IFG;
          end
        end
        PAD: begin
          o_valid <= 1'b1;
          o_data  <= 8'h00;
          crc     <= crc_upd(crc, 8'h00);
          count   <= cnt_next;
          if (cnt_ext >= MIN_L) state <= FCS;
        end
        FCS: begin
          o_valid <= 1'b1;
          o_data  <= fcs[7:0];
          fidx    <= fidx + 2'd1;
          if (fidx == 2'd3) begin
            o_last  <= 1'b1;
            crc     <= '1;
            count   <= '0;
            ifg_cnt <= 32'd0;
            state   <= (IFG_L == 32'd0) ? IDLE : IFG;
          end
        end
        IFG: begin
          o_valid <= 1'b0;
          ifg_cnt <= ifg_cnt + 32'd1;
          if (ifg_cnt == IFG_L - 32'd1) begin
            ifg_cnt <= 32'd0;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_eth_fcs_append.sv
// tb_eth_fcs_append: randomized self-checking bench comparing the framer output stream to a whole-frame CRC-32 model.
module tb_eth_fcs_append;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst = 1, gate = 1, s_valid = 0, s_last = 0, sel = 1;
  logic [7:0] s_data = 0;
  bit tog = 0;
  logic rdy0, rdy1, v0, v1, l0, l1, e0, e1;
  logic [7:0] d0, d1;
  wire sv0 = s_valid & ~sel;
  wire sv1 = s_valid & sel;
  wire rdy = sel ? rdy1 : rdy0;
  wire ov = sel ? v1 : v0;
  wire ol = sel ? l1 : l0;
  wire oe = sel ? e1 : e0;
  wire [7:0] od = sel ? d1 : d0;
  int n_chk = 0, n_fail = 0, hold_bad = 0;
  bit mv[$], ml[$], me[$];
  logic [7:0] md[$];

  eth_fcs_append #(.MIN_LEN(0), .IFG_LEN(0), .CW(11)) dut0 (
    .clk(clk), .rst(rst), .gate(gate), .s_valid(sv0), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy0), .o_valid(v0), .o_data(d0), .o_last(l0), .o_err(e0));
  eth_fcs_append #(.MIN_LEN(60), .IFG_LEN(12), .CW(11)) dut1 (
    .clk(clk), .rst(rst), .gate(gate), .s_valid(sv1), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy1), .o_valid(v1), .o_data(d1), .o_last(l1), .o_err(e1));

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    gate = tog ? ~gate : 1'b1;
  end

  // one record per gate cycle; on non-gate cycles the outputs must not move
  initial begin
    logic [10:0] prev, cur;
    bit g;
    prev = '0;
    forever begin
      @(posedge clk);
      g = gate;
      #1;
      cur = {ov, od, ol, oe};
      if (g) begin
        mv.push_back(ov); md.push_back(od); ml.push_back(ol); me.push_back(oe);
      end else if (cur !== prev) hold_bad++;
      prev = cur;
    end
  end

  function automatic logic [31:0] crc_ref(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[k]) begin
      c ^= {24'h0, d[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t frame_ref(input bq_t p, input int min_len);
    bq_t r = p;
    logic [31:0] f;
    while (r.size() < min_len) r.push_back(8'h00);
    f = ~crc_ref(r);
    for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
    return r;
  endfunction

  function automatic bq_t rand_frame(input int n);
    bq_t r;
    for (int k = 0; k < n; k++) r.push_back(8'($urandom));
    return r;
  endfunction

  function automatic bq_t got();
    bq_t r;
    foreach (mv[k]) if (mv[k]) r.push_back(md[k]);
    return r;
  endfunction

  function automatic int lasts();
    int n = 0;
    foreach (ml[k]) if (ml[k]) n++;
    return n;
  endfunction

  task automatic clear();
    mv.delete(); md.delete(); ml.delete(); me.delete();
  endtask

  task automatic send(input bq_t f, input int drop_at, output int stalls);
    int i = 0, t = 0;
    stalls = 0;
    while (i < f.size() && t < 4000) begin
      @(negedge clk);
      s_valid = (i != drop_at);
      s_data = f[i];
      s_last = (i == f.size() - 1);
      #1;
      t++;
      if (gate && !s_valid) begin
        @(posedge clk);
        return;
      end
      if (gate && !rdy) stalls++;
      if (gate && rdy) i++;
      @(posedge clk);
    end
    if (i < f.size()) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: sent %0d of %0d bytes", i, f.size());
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 0;
    s_last = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk += 6;
    if (v1 !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", v1); end
    if (d1 !== 8'h00) begin n_fail++; $display("FAIL reset_o_data: got %h want 00", d1); end
    if (l1 !== 1'b0) begin n_fail++; $display("FAIL reset_o_last: got %b want 0", l1); end
    if (e1 !== 1'b0) begin n_fail++; $display("FAIL reset_o_err: got %b want 0", e1); end
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid0: got %b want 0", v0); end
    if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", rdy1); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_check_value();
    bq_t p, r, x;
    string s = "123456789";
    int st, first = -1, lastv = -1;
    sel = 0;
    idle(2);
    clear();
    foreach (s[k]) p.push_back(s[k]);
    x = p;
    x.push_back(8'h26); x.push_back(8'h39); x.push_back(8'hF4); x.push_back(8'hCB);
    send(p, -1, st);
    idle(10);
    r = got();
    foreach (mv[k]) if (mv[k]) begin if (first < 0) first = k; lastv = k; end
    n_chk += 3;
    if (r.size() != 13) begin n_fail++; $display("FAIL check_len: got %0d want 13", r.size()); end
    if (lastv - first + 1 != 13) begin n_fail++; $display("FAIL check_span: got %0d want 13", lastv - first + 1); end
    if (lasts() != 1 || lastv < 0 || !ml[lastv]) begin n_fail++; $display("FAIL check_last: got %0d lasts want 1 on final byte", lasts()); end
    foreach (x[k]) begin
      n_chk++;
      if (r[k] !== x[k]) begin n_fail++; $display("FAIL check_byte[%0d]: got %h want %h", k, r[k], x[k]); end
    end
    sel = 1;
    idle(2);
  endtask

  task automatic test_min_pad();
    bq_t p, r, x;
    int st;
    clear();
    p.push_back(8'hAA);
    x = frame_ref(p, 60);
    send(p, -1, st);
    idle(90);
    r = got();
    n_chk += 3;
    if (r.size() != 64) begin n_fail++; $display("FAIL pad_len: got %0d want 64", r.size()); end
    if (crc_ref(r) !== 32'hDEBB20E3) begin n_fail++; $display("FAIL pad_residue: got %h want debb20e3", crc_ref(r)); end
    if (lasts() != 1) begin n_fail++; $display("FAIL pad_lasts: got %0d want 1", lasts()); end
    foreach (x[k]) begin
      n_chk++;
      if (r[k] !== x[k]) begin n_fail++; $display("FAIL pad_byte[%0d]: got %h want %h", k, r[k], x[k]); end
    end
  endtask

  task automatic test_gate_toggle();
    bq_t p, r, x;
    int st;
    clear();
    hold_bad = 0;
    tog = 1;
    p = rand_frame(64);
    x = frame_ref(p, 60);
    send(p, -1, st);
    idle(60);
    tog = 0;
    idle(4);
    r = got();
    n_chk += 2;
    if (r.size() != x.size()) begin n_fail++; $display("FAIL toggle_len: got %0d want %0d", r.size(), x.size()); end
    if (hold_bad != 0) begin n_fail++; $display("FAIL toggle_hold: got %0d changes on gate=0 want 0", hold_bad); end
    foreach (x[k]) begin
      n_chk++;
      if (r[k] !== x[k]) begin n_fail++; $display("FAIL toggle_byte[%0d]: got %h want %h", k, r[k], x[k]); end
    end
  endtask

  task automatic test_underrun();
    bq_t p, p2, a, b, x;
    int st, e = -1, nerr = 0, k, idl = 0;
    clear();
    p = rand_frame(40);
    p2 = rand_frame(70);
    x = frame_ref(p2, 60);
    send(p, 20, st);
    send(p2, -1, st);
    idle(40);
    foreach (me[j]) if (me[j]) begin nerr++; if (e < 0) e = j; end
    n_chk += 2;
    if (nerr != 1) begin n_fail++; $display("FAIL underrun_err_pulses: got %0d want 1", nerr); end
    if (lasts() != 1) begin n_fail++; $display("FAIL underrun_lasts: got %0d want 1", lasts()); end
    if (e >= 0) begin
      for (int j = 0; j < e; j++) if (mv[j]) a.push_back(md[j]);
      k = e + 1;
      while (k < mv.size() && !mv[k]) begin idl++; k++; end
      for (int j = k; j < mv.size(); j++) if (mv[j]) b.push_back(md[j]);
      n_chk += 4;
      if (a.size() != 20) begin n_fail++; $display("FAIL underrun_pre_len: got %0d want 20", a.size()); end
      if (mv[e] !== 1'b0) begin n_fail++; $display("FAIL underrun_valid: got %b want 0", mv[e]); end
      if (idl != 12) begin n_fail++; $display("FAIL underrun_ifg: got %0d want 12", idl); end
      if (b.size() != x.size()) begin n_fail++; $display("FAIL underrun_next_len: got %0d want %0d", b.size(), x.size()); end
      for (int j = 0; j < 20; j++) begin
        n_chk++;
        if (a[j] !== p[j]) begin n_fail++; $display("FAIL underrun_pre[%0d]: got %h want %h", j, a[j], p[j]); end
      end
      foreach (x[j]) begin
        n_chk++;
        if (b[j] !== x[j]) begin n_fail++; $display("FAIL underrun_next[%0d]: got %h want %h", j, b[j], x[j]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t p, p2, r, x, x2;
    int st1, st2, k, idl = 0, fl = -1;
    clear();
    p = rand_frame(10);
    p2 = rand_frame(61);
    x = frame_ref(p, 60);
    x2 = frame_ref(p2, 60);
    foreach (x2[j]) x.push_back(x2[j]);
    send(p, -1, st1);
    send(p2, -1, st2);
    idle(40);
    r = got();
    foreach (ml[j]) if (ml[j] && fl < 0) fl = j;
    k = fl + 1;
    while (fl >= 0 && k < mv.size() && !mv[k]) begin idl++; k++; end
    n_chk += 4;
    if (st2 != 66) begin n_fail++; $display("FAIL b2b_stalls: got %0d want 66", st2); end
    if (idl != 12) begin n_fail++; $display("FAIL b2b_ifg: got %0d want 12", idl); end
    if (lasts() != 2) begin n_fail++; $display("FAIL b2b_lasts: got %0d want 2", lasts()); end
    if (r.size() != x.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", r.size(), x.size()); end
    foreach (x[j]) begin
      n_chk++;
      if (r[j] !== x[j]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h want %h", j, r[j], x[j]); end
    end
  endtask

  task automatic test_reset_in_pad();
    bq_t p, p2, r, x;
    int st;
    clear();
    p = rand_frame(5);
    send(p, -1, st);
    idle(5);
    n_chk += 2;
    if (v1 !== 1'b1) begin n_fail++; $display("FAIL rstpad_pre_valid: got %b want 1", v1); end
    if (d1 !== 8'h00) begin n_fail++; $display("FAIL rstpad_pre_data: got %h want 00", d1); end
    rst = 1;
    #1;
    n_chk += 2;
    if (v1 !== 1'b0) begin n_fail++; $display("FAIL rstpad_valid: got %b want 0", v1); end
    if (rdy1 !== gate) begin n_fail++; $display("FAIL rstpad_ready: got %b want %b", rdy1, gate); end
    @(negedge clk);
    rst = 0;
    clear();
    p2 = rand_frame(30);
    x = frame_ref(p2, 60);
    send(p2, -1, st);
    idle(50);
    r = got();
    n_chk += 3;
    if (r.size() != 64) begin n_fail++; $display("FAIL rstpad_len: got %0d want 64", r.size()); end
    if (crc_ref(r) !== 32'hDEBB20E3) begin n_fail++; $display("FAIL rstpad_residue: got %h want debb20e3", crc_ref(r)); end
    if (lasts() != 1) begin n_fail++; $display("FAIL rstpad_lasts: got %0d want 1", lasts()); end
    foreach (x[j]) begin
      n_chk++;
      if (r[j] !== x[j]) begin n_fail++; $display("FAIL rstpad_byte[%0d]: got %h want %h", j, r[j], x[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_min_pad();
    test_gate_toggle();
    test_underrun();
    test_back_to_back();
    test_reset_in_pad();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
